button_conditioner: RTL

- Conditions raw, asynchronous push-button inputs into clean one-cycle press pulses.
- Sits directly upstream of the button-to-FIFO writer, which consumes the pulses as its `buttons` input. Every physical press produces exactly one FIFO entry.
- Three stages per bit: 2-flop synchronizer, shared-tick debouncer with per-bit saturating counters, rising-edge detector.

---
 rtl/button_conditioner_pkg.sv | 30 +++
 rtl/button_conditioner_if.sv | 11 +
 rtl/button_conditioner_sync.sv | 23 ++
 rtl/button_conditioner.sv | 71 +++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared constants and helpers for the button conditioner: default timing
// values, small test-override values and a constant clog2 for counter sizing.
package button_conditioner_pkg;

   localparam int WIDTH_DEF          = 4;
   localparam int SAMPLE_CNT_MAX_DEF = 62500;  // 0.5 ms at 125 MHz
   localparam int PULSE_CNT_MAX_DEF  = 200;    // 100 ms of stable samples

   // Short timing used by simulation so a full debounce takes a dozen cycles.
   localparam int TEST_SAMPLE_CNT_MAX = 4;
   localparam int TEST_PULSE_CNT_MAX  = 3;

   localparam int SYNC_STAGES = 2;

   function automatic int clog2(input int unsigned v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((32'd1 << i) < v) r = i + 1;
      return r;
   endfunction

   // Never return a zero width, even for degenerate parameter values.
   function automatic int cnt_width(input int unsigned v);
      int r;
      r = clog2(v);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw button levels in, debounced level and press pulse out.
interface button_conditioner_if #(parameter int WIDTH = 4);

   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out_level;
   logic [WIDTH-1:0] out_pulse;

   modport master (output in, input out_level, input out_pulse);
   modport slave  (input in, output out_level, output out_pulse);

endinterface

// File: rtl/button_conditioner_sync.sv
// Multi-flop synchronizer bringing asynchronous button levels into the clk domain.
module button_conditioner_sync
   import button_conditioner_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STAGES = SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else     sr <= {sr[STAGES-2:0], d};
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Turns raw push-button levels into a debounced level and one registered
// pulse per accepted press, for the button-to-FIFO writer downstream.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int WIDTH          = WIDTH_DEF,
   parameter int SAMPLE_CNT_MAX = SAMPLE_CNT_MAX_DEF,
   parameter int PULSE_CNT_MAX  = PULSE_CNT_MAX_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   button_conditioner_if.slave  bus
);

   localparam int TW = cnt_width(SAMPLE_CNT_MAX);
   localparam int CW = cnt_width(PULSE_CNT_MAX + 1);

   logic [WIDTH-1:0]         sync;
   logic [TW-1:0]            tick_cnt;
   logic                     tick;
   logic [WIDTH-1:0][CW-1:0] cnt;
   logic [WIDTH-1:0]         level;
   logic [WIDTH-1:0]         level_d;
   logic [WIDTH-1:0]         pulse;

   button_conditioner_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.in),
      .q   (sync)
   );

   // One sample tick shared by every bit keeps the per-bit state to a counter.
   assign tick = (tick_cnt == TW'(SAMPLE_CNT_MAX - 1));

   always_ff @(posedge clk) begin
      if (rst || tick) tick_cnt <= '0;
      else             tick_cnt <= tick_cnt + TW'(1);
   end

   // Any low synchronized sample restarts the debounce; a full count saturates.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (rst || !sync[i])
            cnt[i] <= '0;
         else if (tick && (cnt[i] < CW'(PULSE_CNT_MAX)))
            cnt[i] <= cnt[i] + CW'(1);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_level
      assign level[i] = (cnt[i] == CW'(PULSE_CNT_MAX));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level_d <= '0;
         pulse   <= '0;
      end else begin
         level_d <= level;
         pulse   <= level & ~level_d;
      end
   end

   assign bus.out_level = level;
   assign bus.out_pulse = pulse;

endmodule
